// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divide sequencer.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  localparam int          DIV_ITER  = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  function automatic logic [63:0] pack_result(input logic [31:0] hi, input logic [31:0] lo);
    return {hi, lo};
  endfunction

  function automatic logic [31:0] res_hi(input logic [63:0] r);
    return r[63:32];
  endfunction

  function automatic logic [31:0] res_lo(input logic [63:0] r);
    return r[31:0];
  endfunction

  // Two's-complement magnitude, applied only for signed requests.
  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (32'd0 - x) : x;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// EX-side request/response bundle for the divide sequencer.
interface div_ctrl_if #(parameter int DATA_W = 32);

  logic                  start_i;
  logic                  signed_i;
  logic [DATA_W-1:0]     dividend_i;
  logic [DATA_W-1:0]     divisor_i;
  logic [DATA_W-1:0]     tag_i;
  logic                  flush_i;
  logic                  stall_o;
  logic                  busy_o;
  logic                  done_o;
  logic [2*DATA_W-1:0]   result_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, tag_i, flush_i,
    input  stall_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, tag_i, flush_i,
    output stall_o, busy_o, done_o, result_o
  );

endinterface

// File: rtl/div_core.sv
// Unsigned restoring divider datapath: one quotient bit per step_i.
module div_core #(parameter int DATA_W = 32) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] quot_o,
  output logic [DATA_W-1:0] rem_o
);

  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] dsr_q;
  logic [DATA_W:0]   shift_s;
  logic [DATA_W-1:0] sub_s;
  logic              ge_s;

  // quo_q shifts dividend bits out of the top while quotient bits enter at the bottom.
  assign shift_s = {rem_q, quo_q[DATA_W-1]};
  assign ge_s    = shift_s >= {1'b0, dsr_q};
  assign sub_s   = shift_s[DATA_W-1:0] - dsr_q;

  // Partial remainder, quotient and divisor registers.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      rem_q <= {DATA_W{1'b0}};
      quo_q <= {DATA_W{1'b0}};
      dsr_q <= {DATA_W{1'b0}};
    end else if (load_i) begin
      rem_q <= {DATA_W{1'b0}};
      quo_q <= dividend_i;
      dsr_q <= divisor_i;
    end else if (step_i) begin
      rem_q <= ge_s ? sub_s : shift_s[DATA_W-1:0];
      quo_q <= {quo_q[DATA_W-2:0], ge_s};
    end
  end

  assign quot_o = quo_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/div_ctrl.sv
// Divide sequencer: FSM, tag tracking, sign correction and EX stall generation.
module div_ctrl
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input logic       clock_i,
  input logic       reset_i,
  div_ctrl_if.slave div_if
);

  localparam int               CNT_W    = $clog2(DIV_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

  div_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   tag_q;
  logic                qneg_q;
  logic                rneg_q;
  logic [2*DATA_W-1:0] result_q;

  logic              tag_hit_s;
  logic              div0_s;
  logic              load_s;
  logic              step_s;
  logic [DATA_W-1:0] dvd_mag_s;
  logic [DATA_W-1:0] dsr_mag_s;
  logic [DATA_W-1:0] quot_s;
  logic [DATA_W-1:0] rem_s;

  assign tag_hit_s = div_if.tag_i == tag_q;
  assign div0_s    = div_if.divisor_i == {DATA_W{1'b0}};
  assign load_s    = (state_q == S_IDLE) && div_if.start_i && !div_if.flush_i && !div0_s;
  assign step_s    = state_q == S_RUN;
  assign dvd_mag_s = magnitude(div_if.dividend_i, div_if.signed_i);
  assign dsr_mag_s = magnitude(div_if.divisor_i, div_if.signed_i);

  div_core #(.DATA_W(DATA_W)) u_core (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .load_i     (load_s),
    .step_i     (step_s),
    .dividend_i (dvd_mag_s),
    .divisor_i  (dsr_mag_s),
    .quot_o     (quot_s),
    .rem_o      (rem_s)
  );

  // Sequencer state, iteration count, request tag and held result.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      tag_q    <= {DATA_W{1'b0}};
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= {2*DATA_W{1'b0}};
    end else if (div_if.flush_i) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_if.start_i) begin
            tag_q  <= div_if.tag_i;
            cnt_q  <= {CNT_W{1'b0}};
            qneg_q <= div_if.signed_i && (div_if.dividend_i[DATA_W-1] ^ div_if.divisor_i[DATA_W-1]);
            rneg_q <= div_if.signed_i && div_if.dividend_i[DATA_W-1];
            if (div0_s) begin
              result_q <= pack_result(div_if.dividend_i, DIV0_QUOT);
              state_q  <= S_DONE;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!tag_hit_s) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              state_q <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (!tag_hit_s) begin
            state_q <= S_IDLE;
          end else begin
            result_q <= pack_result(rneg_q ? (32'd0 - rem_s) : rem_s,
                                    qneg_q ? (32'd0 - quot_s) : quot_s);
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          // Holding the same request absorbs downstream stalls without re-running.
          if (!(div_if.start_i && tag_hit_s)) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign div_if.stall_o  = reset_i && div_if.start_i && !div_if.flush_i &&
                           !((state_q == S_DONE) && tag_hit_s);
  assign div_if.busy_o   = (state_q == S_RUN) || (state_q == S_FIX);
  assign div_if.done_o   = state_q == S_DONE;
  assign div_if.result_o = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized and directed checks of div_ctrl against an arithmetic reference model.
module tb_div_ctrl;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] last_res;

  always #5 clk = ~clk;

  div_ctrl_if #(.DATA_W(32)) dif ();

  div_ctrl #(.DATA_W(32)) dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .div_if  (dif.slave)
  );

  // Reference: truncating division, remainder carries the dividend's sign.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input logic [31:0] tag, input bit wait_edge, input string nm);
    logic [63:0] exp_res;
    int n_stall, n_busy, want;
    exp_res = ref_div(a, b, sg);
    want = (b == 32'd0) ? 1 : 34;
    if (wait_edge) @(negedge clk);
    dif.start_i = 1'b1; dif.signed_i = sg; dif.dividend_i = a;
    dif.divisor_i = b; dif.tag_i = tag; dif.flush_i = 1'b0;
    #1;
    n_stall = 0;
    n_busy = 0;
    while (dif.stall_o === 1'b1 && n_stall < 100) begin
      n_stall++;
      if (dif.busy_o === 1'b1) n_busy++;
      @(negedge clk); #1;
    end
    n_checks++;
    if (n_stall !== want) $display("FAIL %s stall_cycles: got %0d want %0d", nm, n_stall, want);
    else n_pass++;
    n_checks++;
    if (n_busy !== want - 1) $display("FAIL %s busy_cycles: got %0d want %0d", nm, n_busy, want - 1);
    else n_pass++;
    n_checks++;
    if (dif.done_o !== 1'b1) $display("FAIL %s done: got %b want 1", nm, dif.done_o);
    else n_pass++;
    n_checks++;
    if (dif.result_o !== exp_res) $display("FAIL %s result: got %h want %h", nm, dif.result_o, exp_res);
    else n_pass++;
    last_res = exp_res;
  endtask

  task automatic release_req(input string nm);
    @(negedge clk);
    dif.start_i = 1'b0;
    #1;
    n_checks++;
    if (dif.done_o !== 1'b1 || dif.stall_o !== 1'b0)
      $display("FAIL %s release_done: got done=%b stall=%b want 1/0", nm, dif.done_o, dif.stall_o);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if (dif.done_o !== 1'b0 || dif.busy_o !== 1'b0)
      $display("FAIL %s idle_after: got done=%b busy=%b want 0/0", nm, dif.done_o, dif.busy_o);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dif.start_i = 1'b1; dif.signed_i = 1'b0; dif.dividend_i = 32'd9;
    dif.divisor_i = 32'd3; dif.tag_i = 32'h10; dif.flush_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (dif.stall_o !== 1'b0 || dif.busy_o !== 1'b0 || dif.done_o !== 1'b0)
      $display("FAIL reset_flags: got stall=%b busy=%b done=%b want 0/0/0", dif.stall_o, dif.busy_o, dif.done_o);
    else n_pass++;
    n_checks++;
    if (dif.result_o !== 64'd0) $display("FAIL reset_result: got %h want 0", dif.result_o);
    else n_pass++;
    @(negedge clk);
    dif.start_i = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    do_div(32'd100, 32'd7, 1'b0, 32'h1000, 1'b1, "divu_100_7");
    n_checks++;
    if (dif.result_o !== {32'd2, 32'd14}) $display("FAIL divu_100_7_const: got %h want %h", dif.result_o, {32'd2, 32'd14});
    else n_pass++;
    release_req("divu_100_7");
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h1004, 1'b1, "div_m7_2");
    n_checks++;
    if (dif.result_o !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) $display("FAIL div_m7_2_const: got %h", dif.result_o);
    else n_pass++;
    release_req("div_m7_2");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h1008, 1'b1, "div_ovf");
    n_checks++;
    if (dif.result_o !== {32'd0, 32'h8000_0000}) $display("FAIL div_ovf_const: got %h", dif.result_o);
    else n_pass++;
    release_req("div_ovf");
    do_div(32'd5, 32'd0, 1'b0, 32'h100C, 1'b1, "divu_5_0");
    n_checks++;
    if (res_hi(dif.result_o) !== 32'd5 || res_lo(dif.result_o) !== DIV0_QUOT)
      $display("FAIL divu_5_0_const: got %h", dif.result_o);
    else n_pass++;
    release_req("divu_5_0");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic sg;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      sg = 1'($urandom_range(0, 1));
      do_div(a, b, sg, 32'h4000 + 32'(i) * 32'd4, 1'b1, "random");
      release_req("random");
    end
  endtask

  task automatic test_flush();
    logic [63:0] prev;
    logic seen_done;
    prev = last_res;
    seen_done = 1'b0;
    @(negedge clk);
    dif.start_i = 1'b1; dif.signed_i = 1'b0; dif.dividend_i = 32'd1000;
    dif.divisor_i = 32'd3; dif.tag_i = 32'h2000;
    repeat (10) begin
      @(negedge clk); #1;
      seen_done = seen_done | dif.done_o;
    end
    dif.flush_i = 1'b1;
    #1;
    n_checks++;
    if (dif.stall_o !== 1'b0) $display("FAIL flush_stall: got %b want 0", dif.stall_o);
    else n_pass++;
    @(negedge clk);
    dif.flush_i = 1'b0;
    dif.start_i = 1'b0;
    #1;
    n_checks++;
    if (dif.busy_o !== 1'b0) $display("FAIL flush_idle: got busy=%b want 0", dif.busy_o);
    else n_pass++;
    repeat (40) begin
      @(negedge clk); #1;
      seen_done = seen_done | dif.done_o;
    end
    n_checks++;
    if (seen_done !== 1'b0) $display("FAIL flush_no_done: got %b want 0", seen_done);
    else n_pass++;
    n_checks++;
    if (dif.result_o !== prev) $display("FAIL flush_result: got %h want %h", dif.result_o, prev);
    else n_pass++;
  endtask

  task automatic test_tag_abort();
    @(negedge clk);
    dif.start_i = 1'b1; dif.signed_i = 1'b1; dif.dividend_i = 32'd77;
    dif.divisor_i = 32'd5; dif.tag_i = 32'h3000;
    repeat (5) @(negedge clk);
    dif.tag_i = 32'h3004;
    dif.dividend_i = 32'hFFFF_FF00;
    #1;
    n_checks++;
    if (dif.stall_o !== 1'b1 || dif.busy_o !== 1'b1)
      $display("FAIL abort_pre: got stall=%b busy=%b want 1/1", dif.stall_o, dif.busy_o);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if (dif.busy_o !== 1'b0) $display("FAIL abort_idle: got busy=%b want 0", dif.busy_o);
    else n_pass++;
    do_div(32'hFFFF_FF00, 32'd5, 1'b1, 32'h3004, 1'b0, "after_abort");
    release_req("after_abort");
  endtask

  task automatic test_back_to_back();
    do_div(32'd123456, 32'd789, 1'b0, 32'h5000, 1'b1, "hold_first");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_checks++;
      if (dif.done_o !== 1'b1 || dif.stall_o !== 1'b0 || dif.result_o !== last_res)
        $display("FAIL hold_%0d: got done=%b stall=%b res=%h want 1/0/%h", k, dif.done_o, dif.stall_o, dif.result_o, last_res);
      else n_pass++;
    end
    @(negedge clk);
    dif.tag_i = 32'h5004; dif.signed_i = 1'b1;
    dif.dividend_i = 32'hFFFF_0000; dif.divisor_i = 32'd7;
    #1;
    n_checks++;
    if (dif.stall_o !== 1'b1 || dif.done_o !== 1'b1)
      $display("FAIL new_tag_in_done: got stall=%b done=%b want 1/1", dif.stall_o, dif.done_o);
    else n_pass++;
    do_div(32'hFFFF_0000, 32'd7, 1'b1, 32'h5004, 1'b1, "back_to_back");
    release_req("back_to_back");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    dif.start_i = 1'b1; dif.signed_i = 1'b0; dif.dividend_i = 32'd4242;
    dif.divisor_i = 32'd6; dif.tag_i = 32'h6000;
    repeat (15) @(negedge clk);
    #1;
    n_checks++;
    if (dif.busy_o !== 1'b1) $display("FAIL pre_reset_busy: got %b want 1", dif.busy_o);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dif.stall_o !== 1'b0 || dif.busy_o !== 1'b0 || dif.done_o !== 1'b0 || dif.result_o !== 64'd0)
      $display("FAIL async_reset: got stall=%b busy=%b done=%b res=%h want 0", dif.stall_o, dif.busy_o, dif.done_o, dif.result_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    do_div(32'd4242, 32'd6, 1'b0, 32'h6000, 1'b0, "after_reset");
    release_req("after_reset");
  endtask

  initial begin
    last_res = 64'd0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_tag_abort();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Iterative divide sequencer for the execute stage. It accepts a DIV/DIVU request from EX, runs a 32-iteration unsigned shift-subtract core with sign pre/post-correction, and holds the {HI,LO} result until EX retires the instruction. It generates EX's stall request and detects retirement by instruction tag, so EX needs no ad-hoc done tracking. It cancels cleanly on pipeline flush.

## Interface
- `DATA_W`, 32: operand width. Only 32 is supported.
- `clock_i`  in  1  clock; all state updates on the rising edge.
- `reset_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  EX holds a DIV/DIVU. Level signal, held while EX is stalled.
- `signed_i`  in  1  1 = DIV, 0 = DIVU. Sampled with `start_i` in IDLE.
- `dividend_i`  in  32  rs value.
- `divisor_i`  in  32  rt value.
- `tag_i`  in  32  PC of the EX instruction; identifies the request.
- `flush_i`  in  1  exception/eret flush. Cancels any operation.
- `stall_o`  out  1  EX stall request.
- `busy_o`  out  1  state is RUN or FIX.
- `done_o`  out  1  high in DONE; `result_o` is valid.
- `result_o`  out  64  {remainder (HI), quotient (LO)}.

## Operation
- States: IDLE, RUN, FIX, DONE.
- **IDLE**
  - On `start_i && !flush_i`: latch `tag_q`, sign flags, `|dividend|`, `|divisor|` (`|x|` only when `signed_i`) → RUN; counter = 0.
  - If `divisor_i == 0`: go directly to DONE with quotient 32'hFFFF_FFFF and remainder = `dividend_i`.
- **RUN**
  - One restoring step per cycle: the 33-bit partial remainder shifts in the next dividend bit MSB-first, subtracts the divisor if non-negative, and sets a quotient bit.
  - Counter 0..31; after step 31 → FIX.
- **FIX**
  - Quotient is negated iff signed and operand signs differ.
  - Remainder takes the sign of the dividend.
  - Register `result_o` → DONE.
- **DONE**
  - Stays while `start_i && tag_i == tag_q`, absorbing downstream stalls without restarting.
  - Otherwise → IDLE.
  - A new request with a different tag is accepted in IDLE on the following cycle.
- `stall_o = start_i && !(state == DONE && tag_i == tag_q) && !flush_i`; combinational, and 0 while in reset.
- Abort: `flush_i`, or a `tag_i` change while in RUN or FIX, → IDLE next edge. `result_o` is unchanged and `done_o` is not raised.
- Priority: reset > `flush_i` > tag abort > normal sequencing.
- Signed overflow: 0x8000_0000 / -1 → quotient 0x8000_0000, remainder 0. This falls out naturally from 32-bit magnitudes and needs no special case.
- Reset values: state IDLE, counter 0, `tag_q` 0, `result_o` 0; `done_o`, `busy_o`, `stall_o` all 0.

## Timing
- Normal divide, with the request first seen in IDLE at cycle t0:
  - RUN spans t1..t32, FIX is t33, DONE is t34.
  - `stall_o` is high in t0..t33 (34 cycles) and low in t34.
  - EX captures `result_o` at the end of t34.
- Divide by zero: DONE at t1; `stall_o` high in t0 only.
- `done_o` and `result_o` are registered, with no combinational path from the inputs.
- Back-to-back divides: the second request's t0 is the cycle after the first leaves DONE, which costs one IDLE cycle.
- Flush in any cycle: `stall_o` drops in that same cycle; state is IDLE on the next edge.
- Reset asserted mid-RUN: all outputs return to reset values immediately (asynchronous).

## Structure
- Package `div_pkg`:
  - state enum (IDLE/RUN/FIX/DONE)
  - `DIV_ITER = 32`
  - `DIV0_QUOT = 32'hFFFF_FFFF`
  - `HI`/`LO` field slicing helpers for `result_o`
- Sub-module `div_core`: the unsigned restoring datapath (partial remainder, quotient shift register, `step_i`/`load_i` controls).
- `div_ctrl` owns the FSM, counter, tag compare, sign correction and stall logic.

## Test plan
1. DIVU 100 / 7, tag 0x1000:
   - `stall_o` high for exactly 34 cycles.
   - In t34: `done_o` = 1, `result_o` = {32'd2, 32'd14}.
2. DIV -7 / 2 → `result_o` = {32'hFFFF_FFFF, 32'hFFFF_FFFD}.
   - DIV 0x8000_0000 / 0xFFFF_FFFF → {0, 32'h8000_0000}.
3. DIVU 5 / 0 → DONE at t1 with {32'd5, 32'hFFFF_FFFF}; `stall_o` high in t0 only.
4. `flush_i` pulsed at t10 → `stall_o` = 0 in t10, IDLE at t11.
   - `done_o` never asserts; `result_o` keeps its prior value.
5. After DONE, hold `start_i` with the same tag for 3 extra cycles (memory stall) → no restart, `done_o` stays 1, `stall_o` stays 0.
   - Then change the tag with `start_i` still high → one IDLE cycle, new divide, 34-cycle stall.
6. `reset_i` low at t15 of a divide → outputs reset asynchronously.
   - After release with `start_i` high → a fresh 34-cycle operation.
